// File: rtl/cw_executor_if.sv
// Control-unit <-> executor bundle: control word handshake, memory handshake,
// latched datapath fields and strobes.
interface cw_executor_if;
  logic        cw_valid;
  logic        cw_ready;
  logic [35:0] control_word;
  logic [2:0]  ns_in;
  logic [3:0]  alu_flags;
  logic        mem_ack;
  logic [3:0]  micro_state;
  logic [3:0]  status;
  logic [4:0]  fs;
  logic [4:0]  sa;
  logic [4:0]  sb;
  logic [4:0]  da;
  logic        c0;
  logic        b_sel;
  logic        add_tri_sel;
  logic        data_tri_sel;
  logic        pc_sel;
  logic [1:0]  size;
  logic [1:0]  pc_fs;
  logic [1:0]  mem_cs;
  logic        reg_we;
  logic        ir_load;
  logic        pc_update;
  logic        mem_req;
  logic        mem_we;
  logic        instr_done;
  logic        mem_timeout;

  modport master (
    output cw_valid, control_word, ns_in, alu_flags, mem_ack,
    input  cw_ready, micro_state, status, fs, sa, sb, da, c0, b_sel,
           add_tri_sel, data_tri_sel, pc_sel, size, pc_fs, mem_cs,
           reg_we, ir_load, pc_update, mem_req, mem_we, instr_done, mem_timeout
  );

  modport slave (
    input  cw_valid, control_word, ns_in, alu_flags, mem_ack,
    output cw_ready, micro_state, status, fs, sa, sb, da, c0, b_sel,
           add_tri_sel, data_tri_sel, pc_sel, size, pc_fs, mem_cs,
           reg_we, ir_load, pc_update, mem_req, mem_we, instr_done, mem_timeout
  );
endinterface

// File: rtl/cw_executor.sv
// Microcode control-word executor: latches one control word per microstep and
// sequences EXEC, optional MEM handshake with timeout, and a WB strobe cycle.
module cw_executor #(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  cw_executor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  localparam logic [3:0] TMO_LIM = 4'(TIMEOUT);

  state_t      state;
  logic [35:0] cw_q;
  logic [2:0]  ns_q;
  logic [3:0]  micro_q;
  logic [3:0]  status_q;
  logic [3:0]  tmo_cnt;
  logic        rdy_q;
  logic        reg_we_q;
  logic        ir_load_q;
  logic        pc_upd_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        done_q;
  logic        tmo_q;
  logic [3:0]  tmo_nxt;
  logic        unused_rsvd;

  assign tmo_nxt     = tmo_cnt + 4'd1;
  assign unused_rsvd = cw_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cw_q      <= '0;
      ns_q      <= '0;
      micro_q   <= '0;
      status_q  <= '0;
      tmo_cnt   <= '0;
      rdy_q     <= 1'b1;
      reg_we_q  <= 1'b0;
      ir_load_q <= 1'b0;
      pc_upd_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      reg_we_q  <= 1'b0;
      ir_load_q <= 1'b0;
      pc_upd_q  <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cw_valid && rdy_q) begin
            cw_q  <= bus.control_word;
            ns_q  <= bus.ns_in;
            rdy_q <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cw_q[13:12] != 2'b00) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= cw_q[10];
            tmo_cnt   <= '0;
            state     <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= WB;
          end else if (tmo_nxt == TMO_LIM) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            tmo_q     <= 1'b1;
            tmo_cnt   <= '0;
            micro_q   <= '0;
            rdy_q     <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        WB: begin
          reg_we_q  <= cw_q[15];
          ir_load_q <= cw_q[9];
          pc_upd_q  <= (cw_q[2:1] != 2'b00);
          if (cw_q[8]) status_q <= bus.alu_flags;
          if (ns_q == 3'b000) begin
            done_q  <= 1'b1;
            micro_q <= '0;
          end else begin
            micro_q <= micro_q + 4'd1;
          end
          rdy_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cw_ready     = rdy_q;
  assign bus.micro_state  = micro_q;
  assign bus.status       = status_q;
  assign bus.fs           = cw_q[35:31];
  assign bus.sa           = cw_q[30:26];
  assign bus.sb           = cw_q[25:21];
  assign bus.da           = cw_q[20:16];
  assign bus.c0           = cw_q[14];
  assign bus.mem_cs       = cw_q[13:12];
  assign bus.b_sel        = cw_q[11];
  assign bus.size         = cw_q[7:6];
  assign bus.add_tri_sel  = cw_q[5];
  assign bus.data_tri_sel = cw_q[4];
  assign bus.pc_sel       = cw_q[3];
  assign bus.pc_fs        = cw_q[2:1];
  assign bus.reg_we       = reg_we_q;
  assign bus.ir_load      = ir_load_q;
  assign bus.pc_update    = pc_upd_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.instr_done   = done_q;
  assign bus.mem_timeout  = tmo_q;

endmodule

// File: tb/tb_cw_executor.sv
// Directed bench for cw_executor: each microstep's expected outcome is queued
// when the word is driven and compared when the executor returns to IDLE.
module tb_cw_executor;
  localparam int TMO = 15;

  logic clk;
  logic rst_n;
  cw_executor_if bus ();

  cw_executor #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       reg_we, ir_load, pc_update, instr_done, mem_timeout;
    logic [3:0] micro, status;
    logic [4:0] fs, da;
    int         lat, mem_cyc, we_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] model_status = 4'd0;
  logic [3:0] model_micro = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk_cw(input logic [4:0] fs, input logic w_reg,
                                        input logic [1:0] mem_cs, input logic mem_w,
                                        input logic ir_ld, input logic st_ld,
                                        input logic [1:0] pc_fs);
    return {fs, 5'd3, 5'd4, 5'd7, w_reg, 1'b0, mem_cs, 1'b1, mem_w, ir_ld, st_ld,
            2'b10, 1'b0, 1'b1, 1'b0, pc_fs, 1'b0};
  endfunction

  task automatic run_word(input string tag, input logic [35:0] cw, input logic [2:0] ns,
                          input logic [3:0] flags, input int ack_wait, input bit busy_valid);
    exp_t e;
    bit   mem, tmo, fin;
    int   lat, mcyc, wcyc;
    mem = (cw[13:12] != 2'b00);
    tmo = mem && (ack_wait < 0 || ack_wait + 1 > TMO);
    e.mem_cyc     = !mem ? 0 : (tmo ? TMO : ack_wait + 1);
    e.we_cyc      = cw[10] ? e.mem_cyc : 0;
    e.lat         = !mem ? 2 : (tmo ? 1 + TMO : e.mem_cyc + 2);
    e.reg_we      = !tmo && cw[15];
    e.ir_load     = !tmo && cw[9];
    e.pc_update   = !tmo && (cw[2:1] != 2'b00);
    e.instr_done  = !tmo && (ns == 3'b000);
    e.mem_timeout = tmo;
    if (!tmo && cw[8]) model_status = flags;
    model_micro   = (tmo || ns == 3'b000) ? 4'd0 : model_micro + 4'd1;
    e.status      = model_status;
    e.micro       = model_micro;
    e.fs          = cw[35:31];
    e.da          = cw[20:16];

    check({tag, "_ready_pre"}, 32'(bus.cw_ready), 32'd1);
    bus.cw_valid     = 1'b1;
    bus.control_word = cw;
    bus.ns_in        = ns;
    bus.alu_flags    = flags;
    sb_q.push_back(e);
    @(negedge clk);
    bus.cw_valid = busy_valid;
    if (busy_valid) bus.control_word = ~cw;
    check({tag, "_ready_busy"}, 32'(bus.cw_ready), 32'd0);
    lat = 0; mcyc = 0; wcyc = 0; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) mcyc++;
      if (bus.mem_we) wcyc++;
      bus.mem_ack = bus.mem_req && ack_wait >= 0 && mcyc == ack_wait + 1;
      if (bus.cw_ready) fin = 1;
    end
    bus.cw_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    check({tag, "_completed"}, 32'(fin), 32'd1);
    e = sb_q.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_mem_req_cyc"}, 32'(mcyc), 32'(e.mem_cyc));
    check({tag, "_mem_we_cyc"}, 32'(wcyc), 32'(e.we_cyc));
    check({tag, "_reg_we"}, 32'(bus.reg_we), 32'(e.reg_we));
    check({tag, "_ir_load"}, 32'(bus.ir_load), 32'(e.ir_load));
    check({tag, "_pc_update"}, 32'(bus.pc_update), 32'(e.pc_update));
    check({tag, "_instr_done"}, 32'(bus.instr_done), 32'(e.instr_done));
    check({tag, "_mem_timeout"}, 32'(bus.mem_timeout), 32'(e.mem_timeout));
    check({tag, "_micro"}, 32'(bus.micro_state), 32'(e.micro));
    check({tag, "_status"}, 32'(bus.status), 32'(e.status));
    check({tag, "_fs"}, 32'(bus.fs), 32'(e.fs));
    check({tag, "_da"}, 32'(bus.da), 32'(e.da));
    @(negedge clk);
    check({tag, "_pulses_clear"},
          32'({bus.reg_we, bus.ir_load, bus.pc_update, bus.instr_done, bus.mem_timeout, bus.mem_req}),
          32'd0);
  endtask

  initial begin
    logic [35:0] w;
    rst_n = 1'b0;
    bus.cw_valid = 1'b0; bus.control_word = '0; bus.ns_in = '0;
    bus.alu_flags = '0; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_micro", 32'(bus.micro_state), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_fs", 32'(bus.fs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.cw_ready), 32'd1);

    // ADD: no memory, PC update, status untouched.
    w = mk_cw(5'b01000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01);
    run_word("add", w, 3'b000, 4'b1111, -1, 1'b0);
    // ADDS: flags captured; extra cw_valid while busy must be ignored.
    w = mk_cw(5'b01000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    run_word("adds", w, 3'b000, 4'b0110, -1, 1'b1);
    // Memory write acked on the fourth MEM cycle.
    w = mk_cw(5'b00010, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00);
    run_word("memw", w, 3'b000, 4'b0000, 3, 1'b0);
    // Step to micro_state 1, then a memory access that never completes.
    w = mk_cw(5'b00001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    run_word("step1", w, 3'b001, 4'b0000, -1, 1'b0);
    w = mk_cw(5'b00011, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 2'b11);
    run_word("tmo", w, 3'b001, 4'b1111, -1, 1'b0);
    // Two-step instruction: micro_state 0 -> 1 -> 0 with one instr_done.
    w = mk_cw(5'b00100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    run_word("ms_a", w, 3'b001, 4'b0000, -1, 1'b0);
    w = mk_cw(5'b00101, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10);
    run_word("ms_b", w, 3'b000, 4'b0000, -1, 1'b0);
    // Ack on the last allowed cycle still succeeds.
    w = mk_cw(5'b00110, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00);
    run_word("ack_edge", w, 3'b000, 4'b1001, TMO - 1, 1'b0);

    // Reset in the middle of a memory access.
    w = mk_cw(5'b00111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    run_word("pre_rst", w, 3'b001, 4'b0000, -1, 1'b0);
    bus.cw_valid = 1'b1;
    bus.control_word = mk_cw(5'b11111, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01);
    bus.ns_in = 3'b001;
    @(negedge clk);
    bus.cw_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(bus.mem_req), 32'd0);
    check("arst_mem_we", 32'(bus.mem_we), 32'd0);
    check("arst_micro", 32'(bus.micro_state), 32'd0);
    check("arst_status", 32'(bus.status), 32'd0);
    check("arst_fields", 32'({bus.fs, bus.da, bus.mem_cs, bus.pc_fs}), 32'd0);
    check("arst_pulses", 32'({bus.reg_we, bus.ir_load, bus.pc_update, bus.instr_done, bus.mem_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_status = 4'd0;
    model_micro  = 4'd0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.cw_ready), 32'd1);
    check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    w = mk_cw(5'b01000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01);
    run_word("post_rst", w, 3'b000, 4'b0011, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cw_executor.md
CW_EXECUTOR -- requirements
Module: cw_executor

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles in MEM waiting for mem_ack before abort.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 cw_valid  in  1  control word from the control unit is valid.
REQ-005 cw_ready  out  1  executor can accept a control word.
REQ-006 control_word  in  36  packed word: [35:31]FS [30:26]SA [25:21]SB [20:16]DA [15]w_reg [14]C0 [13:12]mem_cs [11]B_Sel [10]mem_w [9]IR_load [8]status_load [7:6]size [5]add_tri_sel [4]data_tri_sel [3]PC_sel [2:1]PC_FS [0]reserved.
REQ-007 ns_in  in  3  next-microstate code from the control unit; sampled with control_word.
REQ-008 alu_flags  in  4  NZCV from the ALU.
REQ-009 mem_ack  in  1  memory completion.
REQ-010 micro_state  out  4  current microstep index, fed back to the control unit state input.
REQ-011 status  out  4  registered NZCV.
REQ-012 fs/sa/sb/da  out  5 each  latched field values.
REQ-013 c0, b_sel, add_tri_sel, data_tri_sel, pc_sel  out  1 each; size, pc_fs, mem_cs  out  2 each: latched field values.
REQ-014 reg_we, ir_load, pc_update  out  1 each  single-cycle strobes.
REQ-015 mem_req, mem_we  out  1 each  memory handshake.
REQ-016 instr_done, mem_timeout  out  1 each  single-cycle pulses.

Function
REQ-017 FSM states: IDLE, EXEC, MEM, WB.
REQ-018 IDLE: cw_ready=1. On cw_valid&cw_ready, latch control_word and ns_in into a 36+3-bit holding register, then go to EXEC.
REQ-019 Latched field outputs are held constant from the accept edge until the next accept.
REQ-020 EXEC lasts exactly one cycle; datapath settles.
- mem_cs!=2'b00 -> MEM.
- Otherwise -> WB.
REQ-021 MEM: mem_req=1, mem_we=mem_w field. mem_req stays asserted until mem_ack is sampled high; that cycle -> WB.
REQ-022 MEM timeout counter: 4-bit, cleared on MEM entry, increments each MEM cycle without mem_ack. If it reaches TIMEOUT:
- pulse mem_timeout.
- drop mem_req.
- suppress all WB strobes.
- micro_state=0, go to IDLE.
REQ-023 mem_ack arriving on the same cycle the counter reaches TIMEOUT counts as success; no timeout.
REQ-024 WB lasts one cycle and pulses:
- reg_we = w_reg.
- ir_load = IR_load.
- pc_update = 1 when PC_FS!=2'b00.
- status <= alu_flags when status_load=1.
REQ-025 After WB:
- ns_in==3'b000: pulse instr_done, micro_state <= 0, go to IDLE.
- Otherwise: micro_state <= micro_state+1 (4-bit, wraps 15->0), go to IDLE to accept the next microstep word. No instr_done.
REQ-026 cw_valid outside IDLE is ignored. cw_ready=0 in EXEC, MEM and WB.
REQ-027 mem_ack outside MEM is ignored.
REQ-028 Minimum latency from accept to instr_done:
- 2 cycles without memory (EXEC, WB).
- 3+n cycles with memory, where n is the number of wait cycles.

Reset
REQ-029 When reset is low, mid-operation included, the block SHALL immediately:
- go to IDLE.
- clear micro_state, status, holding register, field outputs, timeout counter and all strobes/pulses to 0.
- drive cw_ready=1 once reset deasserts.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- ADD word (FS=01000, w_reg=1, mem_cs=00, PC_FS=01, ns=000) -> reg_we and pc_update pulse exactly 2 cycles after accept, then instr_done. status unchanged.
- ADDS word (status_load=1), alu_flags=4'b0110 -> status=0110 after WB.
- mem_cs=01, mem_w=1, mem_ack after 3 cycles -> mem_req/mem_we high 4 cycles, WB follows, instr_done.
- mem_cs=01, mem_ack never -> mem_timeout after TIMEOUT=15 MEM cycles, no reg_we, back to IDLE.
- ns=001 then ns=000 -> micro_state 0->1->0, single instr_done at the end.
- reset pulled low during MEM -> mem_req drops asynchronously, all outputs 0, cw_ready=1 after release.
